// File: rtl/matrix2x2_operand_loader_pkg.sv
// Shared definitions for the 2x2 matrix operand loader: element width, the
// loader state encoding and the element-to-bit-position packing helper.
package matrix2x2_operand_loader_pkg;

  localparam int ELEM_W = 8;
  localparam int WORD_W = 4 * ELEM_W;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2,
    DROP    = 2'd3
  } state_e;

  // Slot 0 is element [0][0] in the MSBs; slot 3 is [1][1] in the LSBs.
  // The multiplier unpacks in this same order.
  function automatic logic [WORD_W-1:0] put_elem(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        slot,
                                                 input logic [ELEM_W-1:0] elem);
    logic [WORD_W-1:0] w;
    w = word;
    for (int i = 0; i < 4; i++) begin
      if (slot == 2'(i)) w[WORD_W-1-i*ELEM_W -: ELEM_W] = elem;
    end
    return w;
  endfunction

endpackage

// File: rtl/matrix2x2_operand_loader.sv
// Serial-to-packed operand loader: collects A then B (row-major) from a
// valid/ready element stream and presents them until the consumer acks.
module matrix2x2_operand_loader
  import matrix2x2_operand_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] b,
  output logic              mat_valid,
  input  logic              mat_ack,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frames_done,
  output logic [1:0]        dbg_state
);

  // Handshake: an element moves on a rising edge where in_valid and in_ready
  // are both 1; in_ready depends only on the current state.
  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [WORD_W-1:0] sha_q, sha_d;
  logic [WORD_W-1:0] shb_q, shb_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              mat_valid_q, mat_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  assign in_ready = (state_q != PRESENT);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sha_d       = sha_q;
    shb_d       = shb_q;
    a_d         = a_q;
    b_d         = b_q;
    mat_valid_d = mat_valid_q;
    frame_err_d = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          if (in_last) begin
            frame_err_d = 1'b1;
            idx_d       = 3'd0;
          end else begin
            sha_d = put_elem(sha_q, idx_q[1:0], in_data);
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd3) state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          shb_d = put_elem(shb_q, idx_q[1:0], in_data);
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (in_last) begin
              // The last element is merged on its way into b.
              a_d         = sha_q;
              b_d         = shb_d;
              mat_valid_d = 1'b1;
              cnt_d       = cnt_q + CNT_W'(1);
              state_d     = PRESENT;
            end else begin
              frame_err_d = 1'b1;
              state_d     = DROP;
            end
          end else if (in_last) begin
            frame_err_d = 1'b1;
            idx_d       = 3'd0;
            state_d     = LOAD_A;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PRESENT: begin
        if (mat_ack) begin
          mat_valid_d = 1'b0;
          idx_d       = 3'd0;
          state_d     = LOAD_A;
        end
      end
      DROP: begin
        if (accept && in_last) begin
          idx_d   = 3'd0;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD_A;
      idx_q       <= 3'd0;
      sha_q       <= '0;
      shb_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mat_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sha_q       <= sha_d;
      shb_q       <= shb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mat_valid_q <= mat_valid_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign mat_valid   = mat_valid_q;
  assign frame_err   = frame_err_q;
  assign frames_done = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/matrix2x2_operand_loader.md
Name: matrix2x2_operand_loader

Overview:
- Front end for the 2x2 matrix multiplier.
- Accepts a serial stream of 8-bit matrix elements over a valid/ready handshake: A first, then B, each row-major.
- Assembles the elements into the two packed operand words a and b. Presents them with a valid flag and holds them until the consumer acknowledges.
- Detects framing errors and resynchronises on the stream's frame marker.

Parameters:
- ELEM_W, 8, width of one matrix element.
- WORD_W, 4*ELEM_W, width of a packed operand word (derived; do not override).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  ELEM_W  element value.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_last  input  1  marks final (8th) element of a frame.
- in_ready  output  1  loader accepts an element this cycle.
- a  output  WORD_W  packed matrix A: [0][0] in MSBs, then [0][1], [1][0], [1][1].
- b  output  WORD_W  packed matrix B, same order as a.
- mat_valid  output  1  a/b hold a complete, consistent pair.
- mat_ack  input  1  consumer has captured a/b.
- frame_err  output  1  one-cycle pulse on a framing error.
- frames_done  output  CNT_W  count of frames presented, wraps.

Behaviour:
- Reset: one clock, asynchronous, active-low on rst. While rst=0: state=LOAD_A, element index=0, a=0, b=0, mat_valid=0, frame_err=0, frames_done=0, shadow registers=0. in_ready=1 immediately after release.
- Handshake: an element is accepted on a rising edge with in_valid=1 and in_ready=1. in_ready is a function of state only, never of in_valid.
- Element index 0..7:
  - Index k<4 is written to shadow A bits [WORD_W-1-k*ELEM_W -: ELEM_W].
  - Index k>=4 is written to shadow B at the same position for k-4.
- LOAD_A: in_ready=1.
  - Accepted element with in_last=1 → frame_err pulse, index←0, stay in LOAD_A. The frame is discarded.
  - 4th accepted element with in_last=0 → LOAD_B.
- LOAD_B: in_ready=1.
  - Accepted element with in_last=1 at index<7 → frame_err pulse, index←0, LOAD_A.
  - Index 7 with in_last=1 → a←shadow A, b←shadow B, mat_valid←1, frames_done+1, PRESENT.
  - Index 7 with in_last=0 → frame_err pulse, DROP.
- PRESENT: in_ready=0, mat_valid=1; a and b are stable.
  - mat_ack=1 → mat_valid←0, index←0, LOAD_A.
  - mat_ack may be high in the first PRESENT cycle; minimum PRESENT duration is 1 cycle.
- DROP: in_ready=1. Discard elements until an accepted element with in_last=1, then index←0, LOAD_A. No further frame_err pulses are generated while in DROP.
- Output timing:
  - mat_valid rises the cycle after the 8th handshake.
  - Throughput is at best 1 frame per 9 cycles (8 loads plus 1 PRESENT).
- mat_ack outside PRESENT is ignored.
- a and b change only on entry to PRESENT. They keep their last values after ack until the next frame completes.
- frames_done wraps from 2^CNT_W-1 to 0.
- in_valid=0 gaps are allowed anywhere. Index and state hold during gaps.
- Reset asserted mid-frame or in PRESENT: immediate return to reset values; the partial frame is lost.

Decomposition:
- Shared package holds:
  - ELEM_W;
  - the element-to-bit-position function, shared with the multiplier's unpack order;
  - the state encoding LOAD_A, LOAD_B, PRESENT, DROP.
- No sub-module; a single FSM plus a datapath fits one module.

Test Plan:
- Basic load: stream 1,2,3,4,5,6,7,8 (in_last on 8), ack after 3 cycles → a=0x01020304, b=0x05060708, mat_valid high for 3 cycles, frames_done=1.
- Backpressure: during PRESENT, drive in_valid=1 with data 0x55 → in_ready=0, nothing accepted. After ack, the next frame 0x10..0x17 yields a=0x10111213, b=0x14151617.
- Short frame: in_last on 3rd element → frame_err one pulse, mat_valid stays 0. A following clean frame 8..15 yields a=0x08090A0B, b=0x0C0D0E0F.
- Long frame: 10 elements, in_last on 10th → frame_err pulse at 8th element, elements 9-10 dropped, no present. The next clean frame presents correctly.
- Gaps and same-cycle ack: in_valid toggles 1/0 across a frame of 0xFF → a=b=0xFFFFFFFF. mat_ack high on the first PRESENT cycle → mat_valid high exactly 1 cycle.
- Reset mid-frame after 5 elements → all outputs 0, in_ready=1. A clean frame afterward presents correctly with frames_done=1.
